move_replayer: RTL

- Downstream consumer of the maze-solver datapath's move deque.
- After the solver finishes, pops recorded 2-bit moves front-first and re-walks the path from the start cell on its own X/Y coordinate registers.
- Emits one paced, visible step per move for display/checking.
- Reports completion and whether the replay ended on the goal cell (X=15, Y=0).

---
 rtl/replay_pkg.sv | 30 +++
 rtl/replay_pace_timer.sv | 33 +++
 rtl/move_replayer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/replay_pkg.sv
// Shared types and constants for the move replayer.
package replay_pkg;

  // 2-bit move encoding as recorded by the solver
  typedef enum logic [1:0] {
    MV_XINC = 2'b00,
    MV_YDEC = 2'b01,
    MV_XDEC = 2'b10,
    MV_YINC = 2'b11
  } move_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_APPLY   = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } replay_state_t;

  localparam int GOAL_X = 15;
  localparam int GOAL_Y = 0;

  // Counter width able to hold DELAY-1 (at least one bit)
  function automatic int pace_cnt_w(input int delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/replay_pace_timer.sv
// Loadable down-counter that sets the length of the PAUSE state.
// load presets DELAY-1; expired is high while the count sits at zero,
// so a load followed by enable gives exactly DELAY cycles of waiting.
module replay_pace_timer
  import replay_pkg::*;
#(
  parameter int DELAY = 4
) (
  input  logic Clk,
  input  logic our_reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = pace_cnt_w(DELAY);

  logic [CW-1:0] cnt;

  // Down-count toward zero and stop there
  always_ff @(posedge Clk) begin
    if (!our_reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DELAY - 1);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/move_replayer.sv
// Replays the solver's recorded moves from the start cell, one paced step
// per move, and reports completion and whether the goal was reached.
// Optional bounds checking: define REPLAY_BOUNDS_CHECK_EN to stop in ERR on
// a move that would leave the grid; otherwise coordinates wrap.
//
// state   | meaning
// IDLE    | waiting for start after reset
// POP     | pop request to the deque this cycle
// CAPTURE | deque data valid, latch it into move_dir
// APPLY   | update position on the exit edge
// PAUSE   | STEP_DELAY cycles of visible hold
// DONE    | replay finished, done held
// ERR     | out-of-bounds move rejected (bounds-check build only)
module move_replayer
  import replay_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int START_X    = 0,
  parameter int START_Y    = 15,
  parameter int STEP_DELAY = 4,
  parameter int MAX_STEPS  = 255,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             our_reset,
  input  logic             start,
  input  logic             is_deque_empty,
  input  logic [1:0]       stack_out,
  output logic             pop_front,
  output logic [WIDTH-1:0] pos_x,
  output logic [WIDTH-1:0] pos_y,
  output logic [1:0]       move_dir,
  output logic             move_valid,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             done,
  output logic             at_goal,
  output logic             error
);

  replay_state_t    state;
  logic             pace_expired;
  logic [WIDTH-1:0] next_x;
  logic [WIDTH-1:0] next_y;

  replay_pace_timer #(
    .DELAY(STEP_DELAY)
  ) u_pace (
    .Clk      (Clk),
    .our_reset(our_reset),
    .load     (state == ST_APPLY),
    .enable   (state == ST_PAUSE),
    .expired  (pace_expired)
  );

  // Candidate position after applying the latched move (wraps naturally)
  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    case (move_t'(move_dir))
      MV_XINC: next_x = pos_x + WIDTH'(1);
      MV_YDEC: next_y = pos_y - WIDTH'(1);
      MV_XDEC: next_x = pos_x - WIDTH'(1);
      MV_YINC: next_y = pos_y + WIDTH'(1);
    endcase
  end

`ifdef REPLAY_BOUNDS_CHECK_EN
  logic out_of_bounds;

  // A move is rejected when it would step off either edge of the grid
  always_comb begin
    out_of_bounds = 1'b0;
    case (move_t'(move_dir))
      MV_XINC: out_of_bounds = (pos_x == {WIDTH{1'b1}});
      MV_YDEC: out_of_bounds = (pos_y == '0);
      MV_XDEC: out_of_bounds = (pos_x == '0);
      MV_YINC: out_of_bounds = (pos_y == {WIDTH{1'b1}});
    endcase
  end
`endif

  // Replay sequencer: state, position, captured move and step counter
  always_ff @(posedge Clk) begin
    if (!our_reset) begin
      state      <= ST_IDLE;
      pos_x      <= WIDTH'(START_X);
      pos_y      <= WIDTH'(START_Y);
      move_dir   <= 2'b00;
      step_count <= '0;
      move_valid <= 1'b0;
    end else begin
      move_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            pos_x      <= WIDTH'(START_X);
            pos_y      <= WIDTH'(START_Y);
            step_count <= '0;
            state      <= is_deque_empty ? ST_DONE : ST_POP;
          end
        end
        // Deque drained under us: finish rather than capture stale data
        ST_POP: state <= is_deque_empty ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE: begin
          move_dir <= stack_out;
          state    <= ST_APPLY;
        end
        ST_APPLY: begin
`ifdef REPLAY_BOUNDS_CHECK_EN
          if (out_of_bounds) begin
            state <= ST_ERR;
          end else begin
            pos_x      <= next_x;
            pos_y      <= next_y;
            step_count <= step_count + CNT_W'(1);
            move_valid <= 1'b1;
            state      <= ST_PAUSE;
          end
`else
          pos_x      <= next_x;
          pos_y      <= next_y;
          step_count <= step_count + CNT_W'(1);
          move_valid <= 1'b1;
          state      <= ST_PAUSE;
`endif
        end
        ST_PAUSE: begin
          if (pace_expired) begin
            if (is_deque_empty || (step_count == CNT_W'(MAX_STEPS)))
              state <= ST_DONE;
            else
              state <= ST_POP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // pop_front is gated by the empty flag so an empty deque is never popped
  assign pop_front = (state == ST_POP) && !is_deque_empty;
  assign busy      = (state == ST_POP) || (state == ST_CAPTURE) ||
                     (state == ST_APPLY) || (state == ST_PAUSE);
  assign done      = (state == ST_DONE) || (state == ST_ERR);
  // Position is frozen in DONE, so evaluating continuously equals evaluating on entry
  assign at_goal   = (state == ST_DONE) &&
                     (pos_x == WIDTH'(GOAL_X)) && (pos_y == WIDTH'(GOAL_Y));

`ifdef REPLAY_BOUNDS_CHECK_EN
  assign error = (state == ST_ERR);
`else
  assign error = 1'b0;
`endif

endmodule
